lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store unit for the RV32I core's MEM stage. It sits between the execute-stage pipeline register and the data-memory AXI bridge. It turns a decoded load/store into a single-word request (byte strobes, lane-replicated write data) and holds that request until the bridge finishes. For loads, it extracts and sign/zero-extends the addressed lane from the returned aligned word and delivers the result to writeback.

## Interface
Parameters:
- (none): all widths are fixed by RV32I.

Ports:
- Reset is RST, synchronous, active-high. The clock is CLK.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- STALL  in  1  global pipeline stall; blocks acceptance only
- FLUSH  in  1  discard the current/incoming op (result suppressed)
- I_VALID  in  1  op present from execute
- I_LOAD / I_STORE  in  1 / 1  op class (mutually exclusive; neither = not for this unit, ignored)
- I_FUNCT3  in  3  RV32I funct3
- I_ADDR  in  32  effective address
- I_WDATA  in  32  rs2 value
- I_RD  in  5  destination register
- BUSY  out  1  = (state != IDLE); pipeline must hold the next op
- RDEN, RDADDR[31:0], RDSIZE[1:0], RDSIGNED  out  request to the bridge
- WREN, WRADDR[31:0], WRSTRB[3:0], WRDATA[31:0]  out  request to the bridge
- RDDATA  in  32  aligned word from the bridge
- LOADING  in  1  bridge still busy with the held request
- O_VALID  out  1  one-cycle result/completion pulse
- O_WE  out  1  register write enable (loads only)
- O_RD  out  5  destination
- O_DATA  out  32  extended load data
- O_EXC  out  1  misaligned or illegal funct3
- O_BADADDR  out  32  faulting address

## Operation
- States: IDLE, ACC, CAPT.
- IDLE:
  - Accept when I_VALID & (I_LOAD | I_STORE) & !STALL & !FLUSH.
  - Latch addr, funct3, rd, type, and formatted wdata/strb.
  - Check for faults: halfword with addr[0]=1, word with addr[1:0]≠0, or funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores.
  - On fault: stay in IDLE, issue no memory request, and next cycle pulse O_VALID with O_EXC=1, O_WE=0, O_BADADDR=addr.
  - Otherwise go to ACC.
- ACC:
  - Drive RDEN (load) or WREN (store) high with stable address and data.
  - Go to CAPT on the first cycle where LOADING=0. On that same edge, drop RDEN/WREN to 0 so the bridge does not restart.
- CAPT:
  - RDDATA is valid in this cycle.
  - Register the extracted result.
  - Go to IDLE, and pulse O_VALID in the following cycle.
- Store formatting:
  - SB: WRDATA={4{b}}, WRSTRB=4'b0001<<addr[1:0].
  - SH: WRDATA={2{h}}, WRSTRB=4'b0011<<{addr[1],1'b0}.
  - SW: WRDATA=word, WRSTRB=4'b1111.
  - WRADDR=addr (the bridge word-aligns it).
- Load formatting:
  - RDADDR=addr, RDSIZE=funct3[1:0], RDSIGNED=!funct3[2].
  - Byte = RDDATA[8*addr[1:0]+:8]; half = RDDATA[16*addr[1]+:16].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Stores complete with O_VALID=1, O_WE=0, O_DATA=0.
- FLUSH in ACC or CAPT:
  - Does not abort; the AXI transaction must finish.
  - Set a kill flag; the completion pulse is then suppressed (O_VALID stays 0).
  - A store already in ACC still reaches memory.

## Timing
- Reset values:
  - state=IDLE; BUSY=0.
  - RDEN=WREN=0; all address/data/strobe outputs 0; RDSIZE=0; RDSIGNED=0.
  - O_VALID=O_WE=O_EXC=0; O_RD=0, O_DATA=0, O_BADADDR=0; kill flag cleared.
- RST mid-ACC: immediately return to IDLE and drop requests. A bridge-side reset is expected concurrently.
- Accept edge E0. RDEN/WREN are high from E0+1 until the edge after the first LOADING=0 cycle.
- With N cycles of LOADING=1 in ACC: request width = N+1 cycles; O_VALID at cycle E0+N+3.
- The O_VALID cycle is IDLE, so a new op may be accepted in the same cycle (back-to-back).
- O_* outputs hold their values after the pulse; only O_VALID returns to 0.
- A fault reports O_VALID at E0+1.
- All outputs are registered; there is no combinational path from I_* to memory ports.

## Test plan
- LB at 0x1003, memory word 0x80FF_1234 -> RDADDR=0x1003, RDSIZE=0, RDSIGNED=1; O_DATA=0xFFFF_FF80, O_WE=1, O_RD echoed.
- LHU at 0x2002, word 0x8765_4321 -> O_DATA=0x0000_8765. With LOADING held high 3 cycles, O_VALID at E0+6.
- SH at 0x3002 with rs2=0x1234_ABCD -> WRSTRB=4'b1100, WRDATA=0xABCD_ABCD, WREN for exactly LOADING-cycles+1; then O_VALID=1, O_WE=0.
- LW at 0x4001 -> no RDEN ever; O_VALID at E0+1, O_EXC=1, O_BADADDR=0x4001.
- FLUSH during ACC of SW -> WREN held until LOADING=0, store reaches memory, no O_VALID; BUSY drops, and the next op is accepted normally.
- RST asserted in ACC -> next cycle RDEN=0, BUSY=0, O_VALID=0. Two back-to-back LWs after reset complete in order with correct data.

Source files
------------

// File: rtl/lsu_stage_if.sv
// lsu_stage_if: request/response bundle between the load/store unit and the
// data-memory AXI bridge.
//   RDEN, RDADDR, RDSIZE, RDSIGNED : read request (held until LOADING drops)
//   WREN, WRADDR, WRSTRB, WRDATA   : write request (held until LOADING drops)
//   RDDATA                         : aligned 32-bit word returned by the bridge
//   LOADING                        : bridge still busy with the held request
// Handshake: the LSU raises RDEN or WREN and keeps every request field stable.
// The request is complete on the first cycle the bridge shows LOADING=0 while
// the enable is high. The LSU drops the enable on the following edge so the
// bridge does not start a second transaction. RDDATA is valid in the cycle
// after that completion cycle.
interface lsu_stage_if;
    logic        RDEN;
    logic [31:0] RDADDR;
    logic [1:0]  RDSIZE;
    logic        RDSIGNED;
    logic        WREN;
    logic [31:0] WRADDR;
    logic [3:0]  WRSTRB;
    logic [31:0] WRDATA;
    logic [31:0] RDDATA;
    logic        LOADING;

    modport master (
        output RDEN, RDADDR, RDSIZE, RDSIGNED,
        output WREN, WRADDR, WRSTRB, WRDATA,
        input  RDDATA, LOADING
    );

    modport slave (
        input  RDEN, RDADDR, RDSIZE, RDSIGNED,
        input  WREN, WRADDR, WRSTRB, WRDATA,
        output RDDATA, LOADING
    );
endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: RV32I MEM-stage load/store unit.
// It accepts one decoded load or store from execute and turns it into a single
// word request on the bridge interface. Store data is lane-replicated and the
// store gets byte strobes. The request is held until the bridge finishes. For a
// load, the unit extracts the addressed lane and sign- or zero-extends it.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   STALL, FLUSH  pipeline control (STALL blocks acceptance only)
//   I_*           op from execute (valid, load/store, funct3, addr, wdata, rd)
//   BUSY          unit is not idle; execute must hold its next op
//   mem           bridge request/response (lsu_stage_if.master)
//   O_*           registered completion record; O_VALID pulses for one cycle
//   DBG_STATE_O   current FSM state (0 idle, 1 access, 2 capture)
module lsu_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        I_VALID,
    input  logic        I_LOAD,
    input  logic        I_STORE,
    input  logic [2:0]  I_FUNCT3,
    input  logic [31:0] I_ADDR,
    input  logic [31:0] I_WDATA,
    input  logic [4:0]  I_RD,
    output logic        BUSY,
    lsu_stage_if.master mem,
    output logic        O_VALID,
    output logic        O_WE,
    output logic [4:0]  O_RD,
    output logic [31:0] O_DATA,
    output logic        O_EXC,
    output logic [31:0] O_BADADDR,
    output logic [1:0]  DBG_STATE_O
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_CAPT = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        kill_q, kill_d;
    logic        rden_q, rden_d, wren_q, wren_d;
    logic [31:0] rdaddr_q, rdaddr_d, wraddr_q, wraddr_d, wrdata_q, wrdata_d;
    logic [1:0]  rdsize_q, rdsize_d;
    logic        rdsigned_q, rdsigned_d;
    logic [3:0]  wrstrb_q, wrstrb_d;
    logic        o_valid_q, o_valid_d, o_we_q, o_we_d, o_exc_q, o_exc_d;
    logic [4:0]  o_rd_q, o_rd_d;
    logic [31:0] o_data_q, o_data_d, o_badaddr_q, o_badaddr_d;

    logic        accept, misaligned, f3_illegal;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            rd_q        <= 5'd0;
            kill_q      <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            rdaddr_q    <= 32'd0;
            rdsize_q    <= 2'd0;
            rdsigned_q  <= 1'b0;
            wraddr_q    <= 32'd0;
            wrstrb_q    <= 4'd0;
            wrdata_q    <= 32'd0;
            o_valid_q   <= 1'b0;
            o_we_q      <= 1'b0;
            o_rd_q      <= 5'd0;
            o_data_q    <= 32'd0;
            o_exc_q     <= 1'b0;
            o_badaddr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            kill_q      <= kill_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            rdaddr_q    <= rdaddr_d;
            rdsize_q    <= rdsize_d;
            rdsigned_q  <= rdsigned_d;
            wraddr_q    <= wraddr_d;
            wrstrb_q    <= wrstrb_d;
            wrdata_q    <= wrdata_d;
            o_valid_q   <= o_valid_d;
            o_we_q      <= o_we_d;
            o_rd_q      <= o_rd_d;
            o_data_q    <= o_data_d;
            o_exc_q     <= o_exc_d;
            o_badaddr_q <= o_badaddr_d;
        end
    end

    // Lane extraction uses the held load address; RDDATA is valid in CAPT.
    always_comb begin
        lane_b = 8'd0;
        case (rdaddr_q[1:0])
            2'd0:    lane_b = mem.RDDATA[7:0];
            2'd1:    lane_b = mem.RDDATA[15:8];
            2'd2:    lane_b = mem.RDDATA[23:16];
            default: lane_b = mem.RDDATA[31:24];
        endcase
        lane_h = rdaddr_q[1] ? mem.RDDATA[31:16] : mem.RDDATA[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem.RDDATA;
        endcase
    end

    // Fault detection on the incoming op. An illegal funct3 is a fault even if
    // its size field would also look misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (I_FUNCT3[1:0])
            2'b01:   misaligned = I_ADDR[0];
            2'b10:   misaligned = (I_ADDR[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (I_LOAD)
            f3_illegal = !(I_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            f3_illegal = !(I_FUNCT3 inside {3'b000, 3'b001, 3'b010});
    end

    assign accept = I_VALID && (I_LOAD || I_STORE) && !STALL && !FLUSH;

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        kill_d      = kill_q;
        rden_d      = rden_q;
        wren_d      = wren_q;
        rdaddr_d    = rdaddr_q;
        rdsize_d    = rdsize_q;
        rdsigned_d  = rdsigned_q;
        wraddr_d    = wraddr_q;
        wrstrb_d    = wrstrb_q;
        wrdata_d    = wrdata_q;
        o_valid_d   = 1'b0;
        o_we_d      = o_we_q;
        o_rd_d      = o_rd_q;
        o_data_d    = o_data_q;
        o_exc_d     = o_exc_q;
        o_badaddr_d = o_badaddr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned || f3_illegal) begin
                        // Faults never touch memory; report on the next cycle.
                        o_valid_d   = 1'b1;
                        o_we_d      = 1'b0;
                        o_exc_d     = 1'b1;
                        o_rd_d      = I_RD;
                        o_data_d    = 32'd0;
                        o_badaddr_d = I_ADDR;
                    end else begin
                        state_d   = S_ACC;
                        is_load_d = I_LOAD;
                        funct3_d  = I_FUNCT3;
                        rd_d      = I_RD;
                        kill_d    = 1'b0;
                        if (I_LOAD) begin
                            rden_d     = 1'b1;
                            rdaddr_d   = I_ADDR;
                            rdsize_d   = I_FUNCT3[1:0];
                            rdsigned_d = !I_FUNCT3[2];
                        end else begin
                            wren_d   = 1'b1;
                            wraddr_d = I_ADDR;
                            case (I_FUNCT3[1:0])
                                2'b00: begin
                                    wrdata_d = {4{I_WDATA[7:0]}};
                                    wrstrb_d = 4'b0001 << I_ADDR[1:0];
                                end
                                2'b01: begin
                                    wrdata_d = {2{I_WDATA[15:0]}};
                                    wrstrb_d = 4'b0011 << {I_ADDR[1], 1'b0};
                                end
                                default: begin
                                    wrdata_d = I_WDATA;
                                    wrstrb_d = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            S_ACC: begin
                // A flush cannot abort the bus transaction; it only kills the result.
                if (FLUSH)
                    kill_d = 1'b1;
                if (!mem.LOADING) begin
                    state_d = S_CAPT;
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                end
            end
            S_CAPT: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
                if (!(kill_q || FLUSH)) begin
                    o_valid_d = 1'b1;
                    o_we_d    = is_load_q;
                    o_rd_d    = rd_q;
                    o_data_d  = is_load_q ? load_ext : 32'd0;
                    o_exc_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY         = (state_q != S_IDLE);
    assign DBG_STATE_O  = state_q;
    assign mem.RDEN     = rden_q;
    assign mem.RDADDR   = rdaddr_q;
    assign mem.RDSIZE   = rdsize_q;
    assign mem.RDSIGNED = rdsigned_q;
    assign mem.WREN     = wren_q;
    assign mem.WRADDR   = wraddr_q;
    assign mem.WRSTRB   = wrstrb_q;
    assign mem.WRDATA   = wrdata_q;
    assign O_VALID      = o_valid_q;
    assign O_WE         = o_we_q;
    assign O_RD         = o_rd_q;
    assign O_DATA       = o_data_q;
    assign O_EXC        = o_exc_q;
    assign O_BADADDR    = o_badaddr_q;
endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0, FLUSH = 1'b0, I_VALID = 1'b0, I_LOAD = 1'b0, I_STORE = 1'b0;
    logic [2:0]  I_FUNCT3 = 3'd0;
    logic [31:0] I_ADDR = 32'd0, I_WDATA = 32'd0;
    logic [4:0]  I_RD = 5'd0;
    logic        BUSY, O_VALID, O_WE, O_EXC;
    logic [4:0]  O_RD;
    logic [31:0] O_DATA, O_BADADDR;
    logic [1:0]  DBG_STATE_O;

    lsu_stage_if bus();

    lsu_stage dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .I_VALID(I_VALID), .I_LOAD(I_LOAD), .I_STORE(I_STORE), .I_FUNCT3(I_FUNCT3),
        .I_ADDR(I_ADDR), .I_WDATA(I_WDATA), .I_RD(I_RD), .BUSY(BUSY), .mem(bus),
        .O_VALID(O_VALID), .O_WE(O_WE), .O_RD(O_RD), .O_DATA(O_DATA), .O_EXC(O_EXC),
        .O_BADADDR(O_BADADDR), .DBG_STATE_O(DBG_STATE_O)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] word;
        int          nw;
        logic        exc;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        logic        exp_sgn;
    } vec_t;

    // scoreboard entry: {we, rd, data, exc, badaddr}
    logic [70:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] word,
                                input int nw, input logic exc, input logic [31:0] exp_data,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                                input logic [1:0] exp_size, input logic exp_sgn);
        vec_t v;
        v.ld = ld; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.word = word;
        v.nw = nw; v.exc = exc; v.exp_data = exp_data; v.exp_strb = exp_strb;
        v.exp_wdata = exp_wdata; v.exp_size = exp_size; v.exp_sgn = exp_sgn;
        return v;
    endfunction

    // completion monitor: every O_VALID pops one expected record
    always @(negedge CLK) begin
        if (!RST && O_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_o_valid", 32'd1, 32'd0);
            end else begin
                logic [70:0] e;
                e = exp_q.pop_front();
                check("o_we", {31'd0, O_WE}, {31'd0, e[70]});
                check("o_rd", {27'd0, O_RD}, {27'd0, e[69:65]});
                check("o_data", O_DATA, e[64:33]);
                check("o_exc", {31'd0, O_EXC}, {31'd0, e[32]});
                if (e[32])
                    check("o_badaddr", O_BADADDR, e[31:0]);
            end
        end
    end

    // driver: called just after a negedge; returns at the negedge where O_VALID
    // is seen, so a following call is accepted back-to-back.
    task automatic run_op(input vec_t v, input int flush_at);
        int vk, width, lim, exp_vk;
        vk = 0; width = 0;
        lim = (flush_at != 0) ? v.nw + 6 : 40;
        exp_vk = (flush_at != 0) ? 0 : (v.exc ? 1 : v.nw + 3);
        I_VALID = 1'b1; I_LOAD = v.ld; I_STORE = !v.ld; I_FUNCT3 = v.f3;
        I_ADDR = v.addr; I_WDATA = v.wdata; I_RD = v.rd; bus.RDDATA = v.word;
        if (flush_at == 0)
            exp_q.push_back({v.ld & !v.exc, v.rd, (v.exc || !v.ld) ? 32'd0 : v.exp_data, v.exc, v.addr});
        @(posedge CLK);
        for (int k = 1; k <= lim; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                I_VALID = 1'b0;
                check("busy_after_accept", {31'd0, BUSY}, {31'd0, !v.exc});
                if (!v.exc && v.ld) begin
                    check("rdaddr", bus.RDADDR, v.addr);
                    check("rdsize", {30'd0, bus.RDSIZE}, {30'd0, v.exp_size});
                    check("rdsigned", {31'd0, bus.RDSIGNED}, {31'd0, v.exp_sgn});
                end
                if (!v.exc && !v.ld) begin
                    check("wraddr", bus.WRADDR, v.addr);
                    check("wrstrb", {28'd0, bus.WRSTRB}, {28'd0, v.exp_strb});
                    check("wrdata", bus.WRDATA, v.exp_wdata);
                end
            end
            if (bus.RDEN || bus.WREN)
                width++;
            bus.LOADING = (!v.exc && k <= v.nw);
            if (flush_at != 0)
                FLUSH = (k == flush_at);
            if (O_VALID && vk == 0)
                vk = k;
            if (flush_at == 0 && vk != 0)
                break;
        end
        FLUSH = 1'b0;
        bus.LOADING = 1'b0;
        check("o_valid_cycle", vk, exp_vk);
        check("req_width", width, v.exc ? 0 : v.nw + 1);
        if (flush_at != 0)
            check("busy_after_flush", {31'd0, BUSY}, 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        bus.LOADING = 1'b0;
        bus.RDDATA = 32'd0;
        //                ld f3  addr          wdata          rd  word           nw exc exp_data       strb     exp_wdata      sz sgn
        tbl[0]  = mk(1, 3'd0, 32'h0000_1003, 32'h0,          5,  32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 4'h0,    32'h0,         0, 1);
        tbl[1]  = mk(1, 3'd5, 32'h0000_2002, 32'h0,          6,  32'h8765_4321, 3, 0, 32'h0000_8765, 4'h0,    32'h0,         1, 0);
        tbl[2]  = mk(0, 3'd1, 32'h0000_3002, 32'h1234_ABCD,  7,  32'h0,         2, 0, 32'h0,         4'b1100, 32'hABCD_ABCD, 0, 0);
        tbl[3]  = mk(1, 3'd2, 32'h0000_4001, 32'h0,          8,  32'h0,         0, 1, 32'h0,         4'h0,    32'h0,         0, 0);
        tbl[4]  = mk(1, 3'd2, 32'h0000_4000, 32'h0,          9,  32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 4'h0,    32'h0,         2, 1);
        tbl[5]  = mk(1, 3'd1, 32'h0000_1000, 32'h0,          10, 32'h1234_8001, 0, 0, 32'hFFFF_8001, 4'h0,    32'h0,         1, 1);
        tbl[6]  = mk(1, 3'd4, 32'h0000_1001, 32'h0,          11, 32'h1234_F0AA, 2, 0, 32'h0000_00F0, 4'h0,    32'h0,         0, 0);
        tbl[7]  = mk(0, 3'd0, 32'h0000_5001, 32'h0000_00A5,  12, 32'h0,         0, 0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 0, 0);
        tbl[8]  = mk(0, 3'd2, 32'h0000_6000, 32'hCAFE_F00D,  13, 32'h0,         1, 0, 32'h0,         4'b1111, 32'hCAFE_F00D, 0, 0);
        tbl[9]  = mk(1, 3'd1, 32'h0000_7003, 32'h0,          14, 32'h0,         0, 1, 32'h0,         4'h0,    32'h0,         0, 0);
        tbl[10] = mk(1, 3'd3, 32'h0000_8000, 32'h0,          15, 32'h0,         0, 1, 32'h0,         4'h0,    32'h0,         0, 0);
        tbl[11] = mk(0, 3'd4, 32'h0000_9000, 32'h5555_5555,  16, 32'h0,         0, 1, 32'h0,         4'h0,    32'h0,         0, 0);
        tbl[12] = mk(1, 3'd0, 32'h0000_1000, 32'h0,          17, 32'h0000_007F, 0, 0, 32'h0000_007F, 4'h0,    32'h0,         0, 1);
        tbl[13] = mk(0, 3'd1, 32'h0000_3000, 32'h1234_ABCD,  18, 32'h0,         0, 0, 32'h0,         4'b0011, 32'hABCD_ABCD, 0, 0);
        tbl[14] = mk(1, 3'd4, 32'h0000_1002, 32'h0,          19, 32'h00AB_0000, 1, 0, 32'h0000_00AB, 4'h0,    32'h0,         0, 0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // reset state
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_rden", {31'd0, bus.RDEN}, 32'd0);
        check("rst_wren", {31'd0, bus.WREN}, 32'd0);
        check("rst_rdaddr", bus.RDADDR, 32'd0);
        check("rst_rdsigned", {31'd0, bus.RDSIGNED}, 32'd0);
        check("rst_wrstrb", {28'd0, bus.WRSTRB}, 32'd0);
        check("rst_o_valid", {31'd0, O_VALID}, 32'd0);
        check("rst_o_data", O_DATA, 32'd0);
        check("rst_o_exc", {31'd0, O_EXC}, 32'd0);
        check("rst_o_badaddr", O_BADADDR, 32'd0);

        // table vectors
        foreach (tbl[i]) begin
            run_op(tbl[i], 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // STALL and a non-memory op must not be accepted
        I_VALID = 1'b1; I_LOAD = 1'b1; I_FUNCT3 = 3'd2; I_ADDR = 32'h100; STALL = 1'b1;
        repeat (2) @(negedge CLK);
        check("stall_no_busy", {31'd0, BUSY}, 32'd0);
        check("stall_no_rden", {31'd0, bus.RDEN}, 32'd0);
        STALL = 1'b0; I_LOAD = 1'b0; I_STORE = 1'b0;
        repeat (2) @(negedge CLK);
        check("nonmem_no_busy", {31'd0, BUSY}, 32'd0);
        I_VALID = 1'b0;

        // FLUSH during ACC of SW: store completes on the bus, result suppressed
        run_op(mk(0, 3'd2, 32'h0000_A000, 32'h0BAD_F00D, 20, 32'h0, 3, 0, 32'h0, 4'b1111, 32'h0BAD_F00D, 0, 0), 2);
        run_op(tbl[4], 0);

        // RST asserted mid-ACC
        @(negedge CLK);
        I_VALID = 1'b1; I_LOAD = 1'b1; I_STORE = 1'b0; I_FUNCT3 = 3'd2; I_ADDR = 32'h200;
        bus.LOADING = 1'b1;
        @(negedge CLK);
        I_VALID = 1'b0;
        check("pre_rst_rden", {31'd0, bus.RDEN}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_acc_rden", {31'd0, bus.RDEN}, 32'd0);
        check("rst_acc_busy", {31'd0, BUSY}, 32'd0);
        check("rst_acc_o_valid", {31'd0, O_VALID}, 32'd0);
        RST = 1'b0; bus.LOADING = 1'b0;
        @(negedge CLK);

        // two back-to-back LWs after reset
        run_op(mk(1, 3'd2, 32'h0000_0300, 32'h0, 21, 32'h1111_2222, 0, 0, 32'h1111_2222, 4'h0, 32'h0, 2, 1), 0);
        run_op(mk(1, 3'd2, 32'h0000_0304, 32'h0, 22, 32'h3333_4444, $urandom_range(0, 3), 0, 32'h3333_4444, 4'h0, 32'h0, 2, 1), 0);

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
